// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types: register index, data word, hazard FSM state
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DWAIT   = 2'd2,
        HALTED  = 2'd3
    } hzstate_t;

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - bundle of hazard unit inputs/outputs with block and bench views
interface hazard_unit_if;
    import cpu_types_pkg::*;

    regbits_t rs_de;
    regbits_t rt_de;
    logic     usesRt_de;
    logic     isJr_de;
    logic     jump_de;
    logic     regWr_ex;
    logic     memRead_ex;
    regbits_t regDst_ex;
    logic     branchTaken_ex;
    logic     dREN_me;
    logic     dWEN_me;
    logic     ihit;
    logic     dhit;
    logic     halt_wb;
    logic     en_fe;
    logic     en_de;
    logic     en_ex;
    logic     en_me;
    logic     flush_de;
    logic     flush_ex;
    logic     halted;
    word_t    stallCnt;
    word_t    bubbleCnt;
    word_t    flushCnt;

    modport hu (
        input  rs_de, rt_de, usesRt_de, isJr_de, jump_de,
        input  regWr_ex, memRead_ex, regDst_ex, branchTaken_ex,
        input  dREN_me, dWEN_me, ihit, dhit, halt_wb,
        output en_fe, en_de, en_ex, en_me, flush_de, flush_ex, halted,
        output stallCnt, bubbleCnt, flushCnt
    );

    modport tb (
        output rs_de, rt_de, usesRt_de, isJr_de, jump_de,
        output regWr_ex, memRead_ex, regDst_ex, branchTaken_ex,
        output dREN_me, dWEN_me, ihit, dhit, halt_wb,
        input  en_fe, en_de, en_ex, en_me, flush_de, flush_ex, halted,
        input  stallCnt, bubbleCnt, flushCnt
    );

endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - 32-bit wrapping event counter with synchronous clear
module perf_counter
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  inc,
    output word_t count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush controller with memory-wait FSM and perf counters
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  rs_de,
    input  logic [4:0]  rt_de,
    input  logic        usesRt_de,
    input  logic        isJr_de,
    input  logic        jump_de,
    input  logic        regWr_ex,
    input  logic        memRead_ex,
    input  logic [4:0]  regDst_ex,
    input  logic        branchTaken_ex,
    input  logic        dREN_me,
    input  logic        dWEN_me,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        halt_wb,
    output logic        en_fe,
    output logic        en_de,
    output logic        en_ex,
    output logic        en_me,
    output logic        flush_de,
    output logic        flush_ex,
    output logic        halted,
    output logic [31:0] stallCnt,
    output logic [31:0] bubbleCnt,
    output logic [31:0] flushCnt
);

    hzstate_t state;
    hzstate_t state_nx;
    logic     pendFlush;
    logic     pend_nx;
    logic     flush_evt;
    logic     load_dst;
    logic     lu;
    logic     jr_lu;
    logic     dmiss;
    logic     stall_inc;

    // A load into $0 never produces a value anyone can wait on.
    assign load_dst = memRead_ex && regWr_ex && (regDst_ex != 5'd0);
    assign lu       = load_dst && ((rs_de == regDst_ex) ||
                                   (usesRt_de && (rt_de == regDst_ex)));
    assign jr_lu    = isJr_de && load_dst && (rs_de == regDst_ex);
    assign dmiss    = (dREN_me || dWEN_me) && !dhit;

    always_comb begin
        en_fe     = 1'b1;
        en_de     = 1'b1;
        en_ex     = 1'b1;
        en_me     = 1'b1;
        flush_de  = 1'b0;
        flush_ex  = 1'b0;
        flush_evt = 1'b0;
        state_nx  = RUN;
        pend_nx   = pendFlush;
        if (RST) begin
            pend_nx = 1'b0;
        end else if (state == HALTED || halt_wb) begin
            {en_fe, en_de, en_ex, en_me} = 4'b0000;
            state_nx = HALTED;
        end else if (dmiss) begin
            // Freezing EX also re-presents any taken branch once dhit arrives.
            {en_fe, en_de, en_ex, en_me} = 4'b0000;
            state_nx = DWAIT;
        end else if (branchTaken_ex) begin
            flush_de  = 1'b1;
            flush_ex  = 1'b1;
            flush_evt = 1'b1;
            en_fe     = ihit;
            pend_nx   = !ihit;
        end else if (pendFlush && ihit) begin
            flush_de = 1'b1;
            pend_nx  = 1'b0;
        end else if ((lu || jr_lu) && state != LDSTALL) begin
            en_fe    = 1'b0;
            en_de    = 1'b0;
            flush_ex = 1'b1;
            state_nx = LDSTALL;
        end else if (jump_de && ihit) begin
            flush_de  = 1'b1;
            flush_evt = 1'b1;
        end else if (!ihit) begin
            // A jump seen during a fetch miss waits in decode and flushes later.
            en_fe    = 1'b0;
            en_de    = 1'b0;
            flush_ex = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            pendFlush <= 1'b0;
        end else begin
            state     <= state_nx;
            pendFlush <= pend_nx;
        end
    end

    assign halted    = (state == HALTED) && !RST;
    assign stall_inc = !RST && (state != HALTED) && !(en_fe && en_de && en_ex && en_me);

    perf_counter u_stall_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (stall_inc),
        .count (stallCnt)
    );

    perf_counter u_bubble_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (flush_ex),
        .count (bubbleCnt)
    );

    perf_counter u_flush_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (flush_evt),
        .count (flushCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scoreboard bench for hazard_unit
module tb_hazard_unit;
    import cpu_types_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_de, rt_de, regDst_ex;
    logic        usesRt_de, isJr_de, jump_de, regWr_ex, memRead_ex;
    logic        branchTaken_ex, dREN_me, dWEN_me, ihit, dhit, halt_wb;
    logic        en_fe, en_de, en_ex, en_me, flush_de, flush_ex, halted;
    logic [31:0] stallCnt, bubbleCnt, flushCnt;

    int n_err;
    int n_checks;
    int m_stall;
    int m_bubble;
    int m_flush;

    typedef struct {
        string      tag;
        logic [3:0] en;
        logic [1:0] fl;
        logic       hl;
    } exp_t;

    exp_t sb[$];

    hazard_unit dut (
        .CLK            (clk),
        .RST            (rst),
        .rs_de          (rs_de),
        .rt_de          (rt_de),
        .usesRt_de      (usesRt_de),
        .isJr_de        (isJr_de),
        .jump_de        (jump_de),
        .regWr_ex       (regWr_ex),
        .memRead_ex     (memRead_ex),
        .regDst_ex      (regDst_ex),
        .branchTaken_ex (branchTaken_ex),
        .dREN_me        (dREN_me),
        .dWEN_me        (dWEN_me),
        .ihit           (ihit),
        .dhit           (dhit),
        .halt_wb        (halt_wb),
        .en_fe          (en_fe),
        .en_de          (en_de),
        .en_ex          (en_ex),
        .en_me          (en_me),
        .flush_de       (flush_de),
        .flush_ex       (flush_ex),
        .halted         (halted),
        .stallCnt       (stallCnt),
        .bubbleCnt      (bubbleCnt),
        .flushCnt       (flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rs_de = 5'd0; rt_de = 5'd0; regDst_ex = 5'd0;
        usesRt_de = 1'b0; isJr_de = 1'b0; jump_de = 1'b0;
        regWr_ex = 1'b0; memRead_ex = 1'b0; branchTaken_ex = 1'b0;
        dREN_me = 1'b0; dWEN_me = 1'b0; ihit = 1'b1; dhit = 1'b1; halt_wb = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] dst);
        memRead_ex = 1'b1; regWr_ex = 1'b1; regDst_ex = dst;
    endtask

    // Push the expected outputs for the current inputs, advance the counter model,
    // then compare at the falling edge and let the rising edge commit.
    task automatic step(input string tag, input logic [3:0] en, input logic [1:0] fl,
                        input logic hl, input bit cf);
        exp_t e;
        e.tag = tag; e.en = en; e.fl = fl; e.hl = hl;
        sb.push_back(e);
        if (rst) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            if (en != 4'b1111 && !hl) m_stall++;
            if (fl[0]) m_bubble++;
            if (cf) m_flush++;
        end
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".en"}, {28'd0, en_fe, en_de, en_ex, en_me}, {28'd0, e.en});
        chk({e.tag, ".fl"}, {30'd0, flush_de, flush_ex}, {30'd0, e.fl});
        chk({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.hl});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".stallCnt"}, stallCnt, m_stall);
        chk({tag, ".bubbleCnt"}, bubbleCnt, m_bubble);
        chk({tag, ".flushCnt"}, flushCnt, m_flush);
    endtask

    initial begin
        int s0;
        n_err = 0; n_checks = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("rst", 4'b1111, 2'b00, 1'b0, 0);
        idle();
        chk("post_rst.state", 32'(dut.state), 32'(RUN));
        chk("post_rst.pend", 32'(dut.pendFlush), 32'd0);
        chk_cnt("post_rst");
        step("idle", 4'b1111, 2'b00, 1'b0, 0);

        // lw $2 in EX, add $3,$2,$4 in decode
        load_in_ex(5'd2); rs_de = 5'd2; rt_de = 5'd4; usesRt_de = 1'b1;
        step("lu_rs", 4'b0011, 2'b01, 1'b0, 0);
        chk("lu.state", 32'(dut.state), 32'(LDSTALL));
        step("lu_release", 4'b1111, 2'b00, 1'b0, 0);
        chk("lu.back_run", 32'(dut.state), 32'(RUN));
        chk_cnt("lu");

        idle(); load_in_ex(5'd7); rs_de = 5'd1; rt_de = 5'd7; usesRt_de = 1'b1;
        step("lu_rt", 4'b0011, 2'b01, 1'b0, 0);
        idle();
        step("lu_rt_release", 4'b1111, 2'b00, 1'b0, 0);
        load_in_ex(5'd7); rs_de = 5'd1; rt_de = 5'd7; usesRt_de = 1'b0;
        step("store_rt_no_lu", 4'b1111, 2'b00, 1'b0, 0);

        // lw $31 then jr $31
        idle(); load_in_ex(5'd31); isJr_de = 1'b1; jump_de = 1'b1; rs_de = 5'd31;
        step("jr_lu", 4'b0011, 2'b01, 1'b0, 0);
        memRead_ex = 1'b0; regWr_ex = 1'b0;
        step("jr_go", 4'b1111, 2'b10, 1'b0, 1);
        load_in_ex(5'd0); rs_de = 5'd0;
        step("jr_dst0", 4'b1111, 2'b10, 1'b0, 1);
        chk_cnt("jr");

        idle(); dREN_me = 1'b1; dhit = 1'b0;
        s0 = m_stall;
        step("dmiss1", 4'b0000, 2'b00, 1'b0, 0);
        chk("dmiss.state", 32'(dut.state), 32'(DWAIT));
        for (int i = 2; i <= 4; i++) step($sformatf("dmiss%0d", i), 4'b0000, 2'b00, 1'b0, 0);
        dhit = 1'b1;
        step("dhit", 4'b1111, 2'b00, 1'b0, 0);
        chk("dmiss.stall_delta", stallCnt - 32'(s0), 32'd4);
        chk_cnt("dmiss");

        idle(); branchTaken_ex = 1'b1; ihit = 1'b0;
        step("br_imiss", 4'b0111, 2'b11, 1'b0, 1);
        chk("br.pend_set", 32'(dut.pendFlush), 32'd1);
        branchTaken_ex = 1'b0;
        step("br_pend_wait", 4'b0011, 2'b01, 1'b0, 0);
        ihit = 1'b1;
        step("br_pend_flush", 4'b1111, 2'b10, 1'b0, 0);
        chk("br.pend_clr", 32'(dut.pendFlush), 32'd0);
        chk_cnt("br");

        idle(); branchTaken_ex = 1'b1; load_in_ex(5'd3); rs_de = 5'd3;
        step("br_lu", 4'b1111, 2'b11, 1'b0, 1);
        chk("br_lu.state", 32'(dut.state), 32'(RUN));

        idle(); branchTaken_ex = 1'b1; dWEN_me = 1'b1; dhit = 1'b0;
        step("br_dmiss", 4'b0000, 2'b00, 1'b0, 0);
        dhit = 1'b1;
        step("br_dhit", 4'b1111, 2'b11, 1'b0, 1);

        idle(); ihit = 1'b0;
        step("imiss", 4'b0011, 2'b01, 1'b0, 0);
        chk_cnt("mixed");

        idle(); dREN_me = 1'b1; dhit = 1'b0;
        step("dwait_pre_rst", 4'b0000, 2'b00, 1'b0, 0);
        rst = 1'b1;
        step("rst_in_dwait", 4'b1111, 2'b00, 1'b0, 0);
        idle();
        step("after_rst", 4'b1111, 2'b00, 1'b0, 0);
        chk("after_rst.state", 32'(dut.state), 32'(RUN));
        chk_cnt("after_rst");

        halt_wb = 1'b1;
        step("halt_wb", 4'b0000, 2'b00, 1'b0, 0);
        idle(); branchTaken_ex = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("halted%0d", i), 4'b0000, 2'b00, 1'b1, 0);
        chk_cnt("halted");
        idle(); rst = 1'b1;
        step("rst_halt", 4'b1111, 2'b00, 1'b0, 0);
        idle();
        step("run_again", 4'b1111, 2'b00, 1'b0, 0);
        chk("run_again.state", 32'(dut.state), 32'(RUN));
        chk_cnt("run_again");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline stall/flush controller for the five-stage core. It handles the hazards that operand forwarding cannot cover: load-use into EX or into a decode-stage JR, taken branches and jumps, and memory waits. It also holds halt. It sits beside the forwarding logic and drives the enable and flush inputs of the IF/DE, DE/EX, EX/ME and ME/WB latches. It keeps registered state for multi-cycle memory stalls and deferred flushes, and counts performance events.

## Interface
- No parameters. Register indices are `regbits_t` (5 bits); counters are `word_t` (32 bits).
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- rs_de, rt_de  in  5 each  source registers of the instruction in decode
- usesRt_de  in  1  decode instruction reads rt through the ALU (not store-data-only)
- isJr_de  in  1  decode holds JR
- jump_de  in  1  decode holds J/JAL/JR, target resolved in decode
- regWr_ex, memRead_ex  in  1 each  EX instruction writes a register / is a load
- regDst_ex  in  5  EX destination register
- branchTaken_ex  in  1  branch resolved taken in EX
- dREN_me, dWEN_me  in  1 each  memory-stage data request
- ihit, dhit  in  1 each  cache hits
- halt_wb  in  1  HALT reached writeback
- en_fe, en_de, en_ex, en_me  out  1 each  latch enables (1 = advance)
- flush_de, flush_ex  out  1 each  load a bubble into IF/DE or DE/EX
- halted  out  1  core halted
- stallCnt, bubbleCnt, flushCnt  out  32 each  performance counters

## Operation
- State register, type `hzstate_t`, with four states:
  - RUN: normal execution.
  - LDSTALL: the single bubble cycle after a load-use hazard.
  - DWAIT: waiting for the data cache.
  - HALTED: core stopped.
- The only other state is `pendFlush` (1 bit).
- A load-use hazard (`lu`) exists when all of the following hold:
  - memRead_ex=1, regWr_ex=1 and regDst_ex≠0, and
  - rs_de=regDst_ex, or (usesRt_de=1 and rt_de=regDst_ex).
- A JR load hazard also exists when isJr_de=1, memRead_ex=1 and rs_de=regDst_ex. It is treated the same as `lu`.
- A store's rt sourced from a load is not a hazard; it is covered by forwarding.
- Priority, highest first: RST, halt, data wait, control flush, load-use, instruction wait.
- HALTED (entered when halt_wb=1): all enables 0, flushes 0, halted=1. Only RST leaves this state.
- Data wait, when (dREN_me|dWEN_me) and dhit=0:
  - All enables are 0. Go to DWAIT, and stay there until dhit=1.
  - In the dhit cycle, enables return to 1 and the state goes to RUN.
- Control flush, when branchTaken_ex=1:
  - flush_de=1 and flush_ex=1; enables are 1.
  - If ihit=0 in that cycle, set pendFlush and hold en_fe=0.
  - While pendFlush=1, assert flush_de on the first cycle with ihit=1, then clear pendFlush.
- jump_de=1 with no higher-priority event: flush_de=1 only.
- Load-use, when `lu` holds in RUN:
  - en_fe=0, en_de=0, flush_ex=1. Go to LDSTALL.
  - LDSTALL returns to RUN the next cycle unconditionally; the hazard cannot persist once the load is in MEM.
- Instruction wait, when ihit=0 with nothing above it: en_fe=0, en_de=0, flush_ex=1 (bubble), en_ex=1, en_me=1.
- Counters wrap modulo 2^32:
  - stallCnt increments each cycle in which any enable is 0 and the state is not HALTED.
  - bubbleCnt increments on each flush_ex=1.
  - flushCnt increments on each branch-taken or jump flush.

## Timing
- Enables and flushes are combinational from the current inputs and registered state, valid in the same cycle. Latches sample them on the next edge.
- State, pendFlush and counters update on the rising edge of CLK.
- Reset values (while RST=1 and the cycle after): state RUN, pendFlush 0, all counters 0, halted 0.
- Outputs while RST=1: enables 1, flushes 0.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed instructions. A jump costs 1.
- Simultaneous events:
  - branchTaken_ex with `lu`: the flush wins, no stall, state stays RUN (the consumer is squashed).
  - Data miss with branchTaken_ex: the branch is held. The flush asserts in the dhit cycle, because the EX instruction is frozen and re-presents the branch.
- RST during DWAIT or LDSTALL returns to RUN the next cycle, with no residual stall.

## Structure
- Add `hzstate_t` (2-bit enum: RUN, LDSTALL, DWAIT, HALTED) to `cpu_types_pkg`.
- Add a `hazard_unit_if` interface with modports `hu` (this block) and `tb`.
- Factor the three counters into one sub-module, `perf_counter` (32-bit, enable, synchronous clear), instantiated three times.

## Test plan
- Load-use: `lw $2,0($1)` in EX with `add $3,$2,$4` in decode, ihit=dhit=1 → exactly 1 cycle with en_fe=en_de=0, flush_ex=1 → next cycle RUN; bubbleCnt=1.
- JR after load: `lw $31` in EX, isJr_de=1, rs_de=31 → 1-cycle stall. The same setup with regDst_ex=0 → no stall.
- Data miss: dREN_me=1, dhit=0 for 4 cycles → all enables 0 for 4 cycles, state DWAIT. In the 5th cycle (dhit=1) enables are 1; stallCnt=4.
- Branch with icache miss: branchTaken_ex=1, ihit=0 → flush_de=flush_ex=1, pendFlush=1. On the first ihit=1, flush_de=1 again → pendFlush=0; flushCnt=1.
- Simultaneous branch and `lu` → flushes asserted, no stall, state RUN.
- halt_wb=1 → halted=1 and enables 0 indefinitely. Assert RST for 1 cycle → state RUN, counters 0.
